// File: rtl/wide_bus_pkg.sv
// Shared types and sizing for the wide-bus feeder blocks.
// Default geometry packs 64-bit beats into the 1024-bit ultra-wide bus.
package wide_bus_pkg;

    localparam int unsigned WB_OUT_W = 1024;
    localparam int unsigned WB_IN_W  = 64;
    localparam int unsigned WB_BEATS = WB_OUT_W / WB_IN_W;
    localparam int unsigned WB_IDX_W = $clog2(WB_BEATS);
    localparam int unsigned WB_CW    = $clog2(WB_BEATS) + 1;

    typedef logic [WB_OUT_W-1:0] wb_word_t;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_slot_state_t;

    // Mask covering beat slots 0..cnt of a default-geometry word
    function automatic wb_word_t wb_slot_mask(input logic [WB_IDX_W-1:0] cnt);
        wb_word_t mask;
        mask = '0;
        for (int unsigned b = 0; b < WB_BEATS; b++) begin
            if (WB_IDX_W'(b) <= cnt) begin
                mask[b*WB_IN_W +: WB_IN_W] = {WB_IN_W{1'b1}};
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/wide_bus_beat_packer_if.sv
// Narrow input beat stream plus packed wide output word stream.
// slave is the packer's view; master is the feeder/consumer view.
interface wide_bus_beat_packer_if
    import wide_bus_pkg::*;
#(
    parameter int unsigned IN_W  = WB_IN_W,
    parameter int unsigned OUT_W = WB_OUT_W,
    parameter int unsigned CW    = WB_CW
);

    logic              s_valid;
    logic              s_ready;
    logic [IN_W-1:0]   s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic [CW-1:0]     m_beats;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_beats
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_beats
    );

endinterface

// File: rtl/wide_bus_beat_packer.sv
// Packs IN_W beats LSB-first into one OUT_W word with a single registered output slot.
// s_last closes a short word early; unused upper slots are zero.
module wide_bus_beat_packer
    import wide_bus_pkg::*;
#(
    parameter int unsigned IN_W  = WB_IN_W,
    parameter int unsigned OUT_W = WB_OUT_W
) (
    input  logic                           clk_main_domain_100mhz_primary_oscillator,
    input  logic                           reset_system_wide_asynchronous_active_low_synchronized,
    wide_bus_beat_packer_if.slave          bus,
    input  logic                           flush,
    output logic [31:0]                    words_total
);

    localparam int unsigned BEATS = OUT_W / IN_W;
    localparam int unsigned CW    = $clog2(BEATS) + 1;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    wb_slot_state_t     state_q, state_d;
    logic [IDX_W-1:0]   cnt_q;
    logic [OUT_W-1:0]   asm_q;
    logic [OUT_W-1:0]   m_data_q;
    logic [CW-1:0]      m_beats_q;
    logic [31:0]        words_total_q;

    logic               s_ready;
    logic               accept;
    logic               complete;
    logic               out_take;
    logic [OUT_W-1:0]   merged;
    logic [OUT_W-1:0]   slot_mask;

    assign s_ready  = (state_q == WB_EMPTY) | bus.m_ready;
    assign accept   = bus.s_valid & s_ready & ~flush;
    assign complete = accept & ((cnt_q == IDX_W'(BEATS - 1)) | bus.s_last);
    assign out_take = (state_q == WB_FULL) & bus.m_ready;

    // Current assembly with the offered beat dropped into its slot
    always_comb begin
        merged = asm_q;
        merged[cnt_q*IN_W +: IN_W] = bus.s_data;
    end

    // Keeps slots above the completing beat at zero
    always_comb begin
        slot_mask = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (IDX_W'(b) <= cnt_q) begin
                slot_mask[b*IN_W +: IN_W] = {IN_W{1'b1}};
            end
        end
    end

    always_ff @(posedge clk_main_domain_100mhz_primary_oscillator or
                negedge reset_system_wide_asynchronous_active_low_synchronized) begin
        if (!reset_system_wide_asynchronous_active_low_synchronized) begin
            state_q <= WB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output slot: a completing word always (re)fills it, a bare take empties it
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_EMPTY: if (complete) state_d = WB_FULL;
            WB_FULL:  if (out_take && !complete) state_d = WB_EMPTY;
            default:  state_d = WB_EMPTY;
        endcase
    end

    // Assembly register and beat counter
    always_ff @(posedge clk_main_domain_100mhz_primary_oscillator or
                negedge reset_system_wide_asynchronous_active_low_synchronized) begin
        if (!reset_system_wide_asynchronous_active_low_synchronized) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (flush || complete) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + IDX_W'(1);
            asm_q <= merged;
        end
    end

    // Presented word: loaded only on completion, held otherwise
    always_ff @(posedge clk_main_domain_100mhz_primary_oscillator or
                negedge reset_system_wide_asynchronous_active_low_synchronized) begin
        if (!reset_system_wide_asynchronous_active_low_synchronized) begin
            m_data_q  <= '0;
            m_beats_q <= '0;
        end else if (complete) begin
            m_data_q  <= merged & slot_mask;
            m_beats_q <= CW'(cnt_q) + CW'(1);
        end
    end

    always_ff @(posedge clk_main_domain_100mhz_primary_oscillator or
                negedge reset_system_wide_asynchronous_active_low_synchronized) begin
        if (!reset_system_wide_asynchronous_active_low_synchronized) begin
            words_total_q <= '0;
        end else if (out_take) begin
            words_total_q <= words_total_q + 32'd1;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = (state_q == WB_FULL);
    assign bus.m_data   = m_data_q;
    assign bus.m_beats  = m_beats_q;
    assign words_total  = words_total_q;

endmodule
